// File: rtl/alu_cmd_driver.sv
// ---------------------------------------------------------------------------
// alu_cmd_driver
//   Command sequencer for the accumulator ALU. A small FIFO of (opcode,
//   operand) commands is loaded through wr_*. A start strobe replays the FIFO
//   to the ALU one command at a time over a valid/ready channel. The block
//   waits for each response, keeps the last result and counts completed
//   commands.
//
// Optional feature macro: ALU_CMD_DRIVER_TIMEOUT_EN
//   When defined, an 8-bit watchdog aborts a stalled WAIT_RSP, flushes the
//   FIFO and raises the sticky 'timeout' output.
//
// Ports
//   clk, reset_n              clock, synchronous active-low reset
//   wr_en, wr_op, wr_data     command push (IDLE only, dropped when full/busy)
//   start                     begin executing the FIFO contents
//   cmd_valid/op/a, cmd_ready command channel to the ALU
//   rsp_valid, rsp_data       response channel from the ALU
//   busy, done                run in progress / one-cycle end-of-program pulse
//   last_result, exec_count   last captured result / commands completed
//   fill                      FIFO occupancy
//   wr_err                    one-cycle pulse, cycle after a rejected write
//   timeout                   sticky watchdog flag (macro builds only)
// ---------------------------------------------------------------------------
module alu_cmd_driver #(
    parameter int DEPTH = 8,
    parameter int OPW   = 3,
    parameter int DW    = 4,
    parameter int RW    = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       wr_en,
    input  logic [OPW-1:0]             wr_op,
    input  logic [DW-1:0]              wr_data,
    input  logic                       start,
    output logic                       cmd_valid,
    output logic [OPW-1:0]             cmd_op,
    output logic [DW-1:0]              cmd_a,
    input  logic                       cmd_ready,
    input  logic                       rsp_valid,
    input  logic [RW-1:0]              rsp_data,
    output logic                       busy,
    output logic                       done,
    output logic [RW-1:0]              last_result,
    output logic [$clog2(DEPTH):0]     exec_count,
    output logic [$clog2(DEPTH):0]     fill,
    output logic                       wr_err
`ifdef ALU_CMD_DRIVER_TIMEOUT_EN
   ,output logic                       timeout
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int FW = PW + 1;
    localparam logic [FW-1:0] FULL_LVL = FW'(DEPTH);
    localparam logic [FW-1:0] ONE_LVL  = FW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_RSP,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [OPW-1:0] r_mem_op [DEPTH];
    logic [DW-1:0]  r_mem_a  [DEPTH];
    logic [PW-1:0]  r_wptr;
    logic [PW-1:0]  r_rptr;
    logic [FW-1:0]  r_fill;
    logic [RW-1:0]  r_last_result;
    logic [FW-1:0]  r_exec_count;
    logic           r_wr_err;

    logic           w_wr_acc;
    logic           w_pop;
    logic           w_start_acc;
    logic           w_handshake;
    logic [FW-1:0]  w_fill_after_wr;
    logic           w_wdog_expire;

    // Writes are only legal in IDLE with room; anything else is rejected.
    assign w_wr_acc        = wr_en && (r_state == S_IDLE) && (r_fill < FULL_LVL);
    assign w_start_acc     = start && (r_state == S_IDLE);
    assign w_handshake     = (r_state == S_ISSUE) && cmd_ready;
    assign w_pop           = (r_state == S_WAIT_RSP) && rsp_valid;
    // Same-cycle write and start: start sees the occupancy including the write.
    assign w_fill_after_wr = r_fill + FW'(w_wr_acc);

`ifdef ALU_CMD_DRIVER_TIMEOUT_EN
    logic [7:0] r_wdog;
    logic       r_timeout;

    assign w_wdog_expire = (r_state == S_WAIT_RSP) && !rsp_valid && (r_wdog == 8'hFF);
    assign timeout       = r_timeout;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wdog    <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (w_handshake) begin
                r_wdog <= '0;
            end else if (r_state == S_WAIT_RSP) begin
                r_wdog <= r_wdog + 8'd1;
            end
            if (w_start_acc) begin
                r_timeout <= 1'b0;
            end else if (w_wdog_expire) begin
                r_timeout <= 1'b1;
            end
        end
    end
`else
    assign w_wdog_expire = 1'b0;
`endif

    // FSM: state register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next-state logic
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = (w_fill_after_wr != '0) ? S_ISSUE : S_DONE;
                end
            end
            S_ISSUE: begin
                if (cmd_ready) begin
                    w_state_nxt = S_WAIT_RSP;
                end
            end
            S_WAIT_RSP: begin
                if (rsp_valid) begin
                    w_state_nxt = (r_fill == ONE_LVL) ? S_DONE : S_ISSUE;
                end else if (w_wdog_expire) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM: outputs. The command bus is forced to zero outside ISSUE so the
    // uninitialised FIFO storage never shows on the pins.
    always_comb begin
        cmd_valid = (r_state == S_ISSUE);
        busy      = (r_state != S_IDLE);
        done      = (r_state == S_DONE);
        cmd_op    = '0;
        cmd_a     = '0;
        if (r_state == S_ISSUE) begin
            cmd_op = r_mem_op[r_rptr];
            cmd_a  = r_mem_a[r_rptr];
        end
    end

    // FIFO storage (no reset needed; occupancy gates every read)
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem_op[r_wptr] <= wr_op;
            r_mem_a[r_wptr]  <= wr_data;
        end
    end

    // FIFO pointers, occupancy, result capture, counters
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_fill        <= '0;
            r_last_result <= '0;
            r_exec_count  <= '0;
            r_wr_err      <= 1'b0;
        end else begin
            r_wr_err <= wr_en && !w_wr_acc;

            if (w_wr_acc) begin
                r_wptr <= r_wptr + PW'(1);
            end

            // Push happens only in IDLE, pop/flush only in WAIT_RSP, so the
            // occupancy update never sees both at once.
            if (w_wdog_expire) begin
                r_rptr <= r_wptr;
                r_fill <= '0;
            end else if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
                r_fill <= r_fill - ONE_LVL;
            end else if (w_wr_acc) begin
                r_fill <= r_fill + ONE_LVL;
            end

            if (w_pop) begin
                r_last_result <= rsp_data;
            end

            if (w_start_acc) begin
                r_exec_count <= '0;
            end else if (w_pop) begin
                r_exec_count <= r_exec_count + ONE_LVL;
            end
        end
    end

    assign last_result = r_last_result;
    assign exec_count  = r_exec_count;
    assign fill        = r_fill;
    assign wr_err      = r_wr_err;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// ---------------------------------------------------------------------------
// tb_alu_cmd_driver
//   Directed self-checking bench for alu_cmd_driver (DEPTH=8, OPW=3, DW=4,
//   RW=8). Inputs change 1 ns after the rising edge; outputs are sampled
//   at the same point, i.e. away from the active edge.
//   Define ALU_CMD_DRIVER_TIMEOUT_EN to also exercise the watchdog.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu_cmd_driver;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       wr_en;
    logic [2:0] wr_op;
    logic [3:0] wr_data;
    logic       start;
    logic       cmd_valid;
    logic [2:0] cmd_op;
    logic [3:0] cmd_a;
    logic       cmd_ready;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       busy;
    logic       done;
    logic [7:0] last_result;
    logic [3:0] exec_count;
    logic [3:0] fill;
    logic       wr_err;
`ifdef ALU_CMD_DRIVER_TIMEOUT_EN
    logic       timeout;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    alu_cmd_driver #(.DEPTH(8), .OPW(3), .DW(4), .RW(8)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .wr_en       (wr_en),
        .wr_op       (wr_op),
        .wr_data     (wr_data),
        .start       (start),
        .cmd_valid   (cmd_valid),
        .cmd_op      (cmd_op),
        .cmd_a       (cmd_a),
        .cmd_ready   (cmd_ready),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .busy        (busy),
        .done        (done),
        .last_result (last_result),
        .exec_count  (exec_count),
        .fill        (fill),
        .wr_err      (wr_err)
`ifdef ALU_CMD_DRIVER_TIMEOUT_EN
       ,.timeout     (timeout)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push(input logic [2:0] op, input logic [3:0] a);
        wr_en   = 1'b1;
        wr_op   = op;
        wr_data = a;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Zero-wait ALU model: always ready, answers the cycle after each
    // handshake with the running handshake number. Bounded by 200 cycles.
    task automatic run_all(output int hs, output bit got_done);
        bit want_rsp = 1'b0;
        hs       = 0;
        got_done = 1'b0;
        cmd_ready = 1'b1;
        for (int c = 0; c < 200; c++) begin
            rsp_valid = 1'b0;
            if (want_rsp) begin
                rsp_valid = 1'b1;
                rsp_data  = 8'(hs);
                want_rsp  = 1'b0;
            end
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (cmd_valid) begin
                hs++;
                want_rsp = 1'b1;
            end
            step();
        end
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
    endtask

    initial begin
        int  hs;
        bit  got_done;

        reset_n   = 1'b0;
        wr_en     = 1'b0;
        wr_op     = '0;
        wr_data   = '0;
        start     = 1'b0;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_data  = '0;
        step();
        step();

        // Reset state
        check("rst_cmd_valid", cmd_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_wr_err", wr_err, 0);
        check("rst_last_result", last_result, 0);
        check("rst_exec_count", exec_count, 0);
        check("rst_fill", fill, 0);
        check("rst_cmd_op", cmd_op, 0);
        check("rst_cmd_a", cmd_a, 0);
`ifdef ALU_CMD_DRIVER_TIMEOUT_EN
        check("rst_timeout", timeout, 0);
`endif
        reset_n = 1'b1;
        step();

        // Basic program: (op0,A=3) then (op7,A=2); ALU returns 3 then 6
        push(3'd0, 4'd3);
        push(3'd7, 4'd2);
        check("basic_fill", fill, 2);
        pulse_start();
        check("basic_valid1", cmd_valid, 1);
        check("basic_busy", busy, 1);
        check("basic_op1", cmd_op, 0);
        check("basic_a1", cmd_a, 3);
        cmd_ready = 1'b1;
        step();
        cmd_ready = 1'b0;
        check("basic_valid_drop", cmd_valid, 0);
        rsp_valid = 1'b1;
        rsp_data  = 8'd3;
        step();
        rsp_valid = 1'b0;
        check("basic_res1", last_result, 8'd3);
        check("basic_cnt1", exec_count, 1);
        check("basic_valid2", cmd_valid, 1);
        check("basic_op2", cmd_op, 7);
        check("basic_a2", cmd_a, 2);
        cmd_ready = 1'b1;
        step();
        cmd_ready = 1'b0;
        rsp_valid = 1'b1;
        rsp_data  = 8'd6;
        step();
        rsp_valid = 1'b0;
        check("basic_done", done, 1);
        check("basic_busy_in_done", busy, 1);
        check("basic_res2", last_result, 8'd6);
        check("basic_cnt2", exec_count, 2);
        check("basic_fill_end", fill, 0);
        step();
        check("basic_done_once", done, 0);
        check("basic_busy_low", busy, 0);

        // Overflow: 9 pushes into 8 entries
        for (int i = 0; i < 8; i++) begin
            push(3'(i), 4'(i + 1));
            check("ovf_no_err", wr_err, 0);
        end
        push(3'd1, 4'd15);
        check("ovf_wr_err", wr_err, 1);
        check("ovf_fill", fill, 8);
        step();
        check("ovf_wr_err_clear", wr_err, 0);
        pulse_start();
        check("ovf_first_op", cmd_op, 0);
        check("ovf_first_a", cmd_a, 1);
        run_all(hs, got_done);
        check("ovf_got_done", 32'(got_done), 1);
        check("ovf_handshakes", 32'(hs), 8);
        check("ovf_last_result", last_result, 8'd8);
        check("ovf_exec_count", exec_count, 8);
        check("ovf_fill_end", fill, 0);
        step();
        check("ovf_idle", busy, 0);

        // Backpressure: cmd_ready held low for 5 cycles
        push(3'd5, 4'd9);
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", cmd_valid, 1);
            check("bp_op", cmd_op, 5);
            check("bp_a", cmd_a, 9);
            step();
        end
        cmd_ready = 1'b1;
        step();
        cmd_ready = 1'b0;
        check("bp_single_hs", cmd_valid, 0);
        rsp_valid = 1'b1;
        rsp_data  = 8'hA5;
        step();
        rsp_valid = 1'b0;
        check("bp_done", done, 1);
        check("bp_result", last_result, 8'hA5);
        check("bp_count", exec_count, 1);
        step();

        // Empty start: done in N+1, no command, count cleared
        pulse_start();
        check("empty_done", done, 1);
        check("empty_no_valid", cmd_valid, 0);
        check("empty_count", exec_count, 0);
        step();
        check("empty_done_once", done, 0);
        check("empty_busy_low", busy, 0);

        // Spurious response while IDLE
        rsp_valid = 1'b1;
        rsp_data  = 8'h33;
        step();
        rsp_valid = 1'b0;
        check("spurious_rsp", last_result, 8'hA5);

        // Write while busy, then reset during WAIT_RSP
        push(3'd1, 4'd1);
        pulse_start();
        push(3'd2, 4'd2);
        check("busy_wr_err", wr_err, 1);
        check("busy_wr_fill", fill, 1);
        cmd_ready = 1'b1;
        step();
        cmd_ready = 1'b0;
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        check("mrst_valid", cmd_valid, 0);
        check("mrst_busy", busy, 0);
        check("mrst_done", done, 0);
        check("mrst_fill", fill, 0);
        check("mrst_count", exec_count, 0);
        check("mrst_result", last_result, 0);
        check("mrst_wr_err", wr_err, 0);
        step();
        check("mrst_no_done", done, 0);

`ifdef ALU_CMD_DRIVER_TIMEOUT_EN
        // Watchdog: ALU never responds
        begin
            int k = 0;
            push(3'd3, 4'd4);
            push(3'd4, 4'd5);
            pulse_start();
            cmd_ready = 1'b1;
            step();
            cmd_ready = 1'b0;
            while (!done && k < 400) begin
                step();
                k++;
            end
            check("wd_cycles", 32'(k), 256);
            check("wd_timeout", timeout, 1);
            check("wd_fill_flushed", fill, 0);
            step();
            check("wd_done_once", done, 0);
            check("wd_sticky", timeout, 1);
            pulse_start();
            check("wd_clear", timeout, 0);
            step();
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
